// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: segment codes,
// digit count and binary width, plus the digit-to-segment lookup.
package ssd_pkg;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 13;
  localparam int BCD_W  = 4 * DIGITS;

  // Active-low {a,b,c,d,e,f,g}, bit6 = a
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    B2B_IDLE,
    B2B_SHIFT
  } b2b_state_e;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one adjust+shift per cycle, 13 cycles
// per conversion; bcd holds the last completed result until the next finishes.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int SH_W = BCD_W + BIN_W;

  b2b_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [SH_W-1:0]   adj, shifted;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= B2B_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    adj = sh_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[BIN_W+4*i +: 4] >= 4'd5)
        adj[BIN_W+4*i +: 4] = adj[BIN_W+4*i +: 4] + 4'd3;
    end
    shifted = adj << 1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      B2B_IDLE: begin
        if (start) begin
          sh_d    = {{BCD_W{1'b0}}, bin};
          cnt_d   = '0;
          state_d = B2B_SHIFT;
        end
      end
      B2B_SHIFT: begin
        sh_d  = shifted;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(BIN_W - 1)) begin
          // Result becomes visible on the same edge busy drops
          bcd_d   = shifted[SH_W-1 -: BCD_W];
          done_d  = 1'b1;
          state_d = B2B_IDLE;
        end
      end
      default: state_d = B2B_IDLE;
    endcase
  end

  assign busy = (state_q == B2B_SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment driver: loads a 13-bit value, converts to BCD and
// time-multiplexes the digits. Define SSD_LEADING_ZERO_BLANK_EN to blank leading zeros.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] num,
  input  logic             num_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       Anode,
  output logic [6:0]       LED_out
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [BCD_W-1:0]  digits;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        anode_q, anode_d;
  logic [6:0]        led_q, led_d;
  logic [DIGITS-1:0] blank;
  logic [3:0]        digit_sel;

  bin2bcd_seq u_b2b (
    .clk   (clk),
    .rst   (rst),
    .start (num_valid),
    .bin   (num),
    .busy  (busy),
    .done  (done),
    .bcd   (digits)
  );

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more-significant digit are zero
  always_comb begin
    blank    = '0;
    blank[3] = (digits[15:12] == 4'd0);
    blank[2] = blank[3] && (digits[11:8] == 4'd0);
    blank[1] = blank[2] && (digits[7:4] == 4'd0);
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    // Outputs follow the next index so Anode and the count stay aligned
    digit_sel = digits[idx_d*4 +: 4];
    anode_d   = ~(4'b0001 << idx_d);
    led_d     = blank[idx_d] ? SEG_BLANK : seg_code(digit_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      anode_q <= 4'b1110;
      led_q   <= SEG_0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      led_q   <= led_d;
    end
  end

  assign Anode   = anode_q;
  assign LED_out = led_q;

endmodule
